// File: rtl/fetch_queue.sv
// ============================================================================
//  Module   : fetch_queue
//  Purpose  : Sequential instruction fetch with single-outstanding memory port,
//             prefetch FIFO toward decode and redirect/flush support.
//             Optional macro FETCH_PERF_EN adds push/redirect counters.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_queue #(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [31:0] instr,
   output logic [31:0] instr_pc,
`ifdef FETCH_PERF_EN
   output logic [31:0] perf_fetch_cnt,
   output logic [31:0] perf_flush_cnt,
`endif
   input  logic        redirect,
   input  logic [31:0] redirect_pc
);

   localparam int                c_ptr_w = $clog2(DEPTH);
   localparam logic [c_ptr_w:0]  c_depth = (c_ptr_w + 1)'(DEPTH);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_DROP = 2'd2
   } state_t;

   state_t               r_state;
   state_t               w_state_next;
   logic [31:0]          r_fetch_pc;
   logic [31:0]          w_fetch_pc_next;
   logic [31:0]          r_tgt;
   logic [31:0]          w_tgt_next;
   logic [c_ptr_w:0]     r_count;
   logic [c_ptr_w:0]     w_count_next;
   logic [c_ptr_w:0]     w_count_pop;
   logic [c_ptr_w:0]     w_count_upd;
   logic [c_ptr_w-1:0]   r_wr_ptr;
   logic [c_ptr_w-1:0]   r_rd_ptr;
   logic [31:0]          r_mem_word [DEPTH];
   logic [31:0]          r_mem_pc   [DEPTH];
   logic                 w_push;
   logic                 w_pop;
   logic [31:0]          w_redirect_tgt;

   assign w_redirect_tgt = {redirect_pc[31:2], 2'b00};
   assign instr_valid    = (r_count != '0) && !redirect;
   assign w_pop          = instr_valid && instr_ready;
   assign w_push         = (r_state == S_REQ) && imem_ack && !redirect;
   assign w_count_pop    = r_count - (c_ptr_w + 1)'(w_pop);
   assign w_count_upd    = w_count_pop + (c_ptr_w + 1)'(w_push);
   assign w_count_next   = redirect ? '0 : w_count_upd;

   assign imem_req  = (r_state == S_REQ) || (r_state == S_DROP);
   assign imem_addr = r_fetch_pc;
   assign instr     = r_mem_word[r_rd_ptr];
   assign instr_pc  = r_mem_pc[r_rd_ptr];

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_fetch_pc <= RESET_PC;
         r_tgt      <= RESET_PC;
      end else begin
         r_state    <= w_state_next;
         r_fetch_pc <= w_fetch_pc_next;
         r_tgt      <= w_tgt_next;
      end
   end

   always_comb begin
      w_state_next    = r_state;
      w_fetch_pc_next = r_fetch_pc;
      w_tgt_next      = r_tgt;
      case (r_state)
         S_IDLE: begin
            if (redirect)
               w_fetch_pc_next = w_redirect_tgt;
            else if (w_count_pop < c_depth)
               w_state_next = S_REQ;
         end
         S_REQ: begin
            if (redirect) begin
               if (imem_ack) begin
                  w_fetch_pc_next = w_redirect_tgt;
                  w_state_next    = S_IDLE;
               end else begin
                  // Request stays on the bus; target parked until the ack drains.
                  w_tgt_next   = w_redirect_tgt;
                  w_state_next = S_DROP;
               end
            end else if (imem_ack) begin
               w_fetch_pc_next = r_fetch_pc + 32'd4;
               if (w_count_upd >= c_depth)
                  w_state_next = S_IDLE;
            end
         end
         S_DROP: begin
            if (redirect) begin
               w_tgt_next = w_redirect_tgt;
               // An ack in the same cycle retires the stale request, so the
               // newest target can be taken immediately.
               if (imem_ack) begin
                  w_fetch_pc_next = w_redirect_tgt;
                  w_state_next    = S_IDLE;
               end
            end else if (imem_ack) begin
               w_fetch_pc_next = r_tgt;
               w_state_next    = S_IDLE;
            end
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset || redirect) begin
         r_count  <= '0;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         r_count <= w_count_next;
         if (w_push)
            r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)
            r_rd_ptr <= r_rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (w_push && !reset) begin
         r_mem_word[r_wr_ptr] <= imem_rdata;
         r_mem_pc[r_wr_ptr]   <= r_fetch_pc;
      end
   end

`ifdef FETCH_PERF_EN
   logic [31:0] r_perf_fetch;
   logic [31:0] r_perf_flush;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_perf_fetch <= '0;
         r_perf_flush <= '0;
      end else begin
         if (w_push)
            r_perf_fetch <= r_perf_fetch + 32'd1;
         if (redirect)
            r_perf_flush <= r_perf_flush + 32'd1;
      end
   end

   assign perf_fetch_cnt = r_perf_fetch;
   assign perf_flush_cnt = r_perf_flush;
`endif

endmodule

`default_nettype wire
